mish_lut_stream: RTL

//  Streaming, multi-lane Mish activation built on a run-time programmable lookup table.

---
 rtl/mish_lut_stream.sv | 95 +++++++++
 1 files changed

// File: rtl/mish_lut_stream.sv
// mish_lut_stream: multi-lane activation through a run-time programmable lookup table on valid/ready streams
module mish_lut_stream #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    localparam int IN_W  = DATA_IN_0_PRECISION_0,
    localparam int OUT_W = DATA_OUT_0_PRECISION_0,
    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0][IN_W-1:0]    data_in_0,
    input  logic                      data_in_0_valid,
    output logic                      data_in_0_ready,
    output logic [N-1:0][OUT_W-1:0]   data_out_0,
    output logic                      data_out_0_valid,
    input  logic                      data_out_0_ready,
    input  logic                      lut_wr_valid,
    output logic                      lut_wr_ready,
    input  logic [IN_W-1:0]           lut_wr_addr,
    input  logic [OUT_W-1:0]          lut_wr_data,
    output logic                      init_busy
);
    if (IN_W < 4 || IN_W > 10 || OUT_W < IN_W ||
        DATA_IN_0_PRECISION_1 < 0 || DATA_OUT_0_PRECISION_1 < 0) begin : g_bad_params
        $error("mish_lut_stream: unsupported parameter combination");
    end

    typedef enum logic {INIT, RUN} state_t;

    state_t                   state_q, state_d;
    logic [IN_W-1:0]          cnt_q, cnt_d;
    logic                     init_busy_q, init_busy_d;
    logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [N-1:0][OUT_W-1:0]  s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [OUT_W-1:0]         lut_q [2**IN_W];
    logic                     adv1, adv2, in_fire, wr_en;
    logic [IN_W-1:0]          wr_addr;
    logic [OUT_W-1:0]         wr_data;

    assign init_busy        = init_busy_q;
    assign lut_wr_ready     = !init_busy_q;
    assign data_in_0_ready  = (state_q == RUN) && adv1;
    assign data_out_0       = s2_data_q;
    assign data_out_0_valid = s2_valid_q;

    // Next-state: init sweep, table write port selection and the two-stage skid-free pipeline
    always_comb begin
        adv2        = !s2_valid_q || data_out_0_ready;
        adv1        = !s1_valid_q || adv2;
        in_fire     = data_in_0_valid && data_in_0_ready;
        state_d     = (state_q == INIT && cnt_q == '1) ? RUN : state_q;
        cnt_d       = (state_q == INIT) ? cnt_q + IN_W'(1) : cnt_q;
        init_busy_d = (state_d == INIT);
        wr_en       = (state_q == INIT) || (lut_wr_valid && lut_wr_ready);
        wr_addr     = (state_q == INIT) ? cnt_q : lut_wr_addr;
        wr_data     = (state_q == INIT) ? OUT_W'($signed(cnt_q)) : lut_wr_data;
        s1_valid_d  = adv1 ? in_fire : s1_valid_q;
        s2_valid_d  = adv2 ? s1_valid_q : s2_valid_q;
        s2_data_d   = adv2 ? s1_data_q : s2_data_q;
        s1_data_d   = s1_data_q;
        for (int i = 0; i < N; i++)
            s1_data_d[i] = adv1 ? lut_q[data_in_0[i]] : s1_data_q[i];
    end

    // FSM, counter and pipeline registers; reset drops in-flight beats and restarts the sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s2_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s1_data_q   <= s1_data_d;
            s2_data_q   <= s2_data_d;
        end
    end

    // Table storage; the lookup into S1 sees the pre-write entry when both happen on one edge
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            lut_q[wr_addr] <= wr_data;
    end
endmodule
